// File: rtl/ball_track_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module   : ball_track_ctrl_pkg
// Brief    : Shared geometry, pixel-format and FSM encoding for ball tracking.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package ball_track_ctrl_pkg;

  localparam int IMG_COLS = 80;
  localparam int IMG_ROWS = 60;
  localparam int RED_BIT  = 11;
  localparam int CNT_W    = 6;
  localparam int COL_W    = 7;
  localparam int ROW_W    = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd63;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_REPORT = 3'd4
  } state_e;

  // One LED per band of ten columns, leftmost band on the MSB.
  function automatic logic [7:0] octant_leds(input logic [COL_W-1:0] col);
    logic [7:0] l;
    l = 8'h80 >> (col / 7'd10);
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ball_track_ctrl_col_hist.sv
//------------------------------------------------------------------------------
// Module   : col_hist
// Brief    : Per-column saturating red-pixel counters with read/clear port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module col_hist
  import ball_track_ctrl_pkg::*;
#(
  parameter int C_COLS = IMG_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_en_i,
  input  logic [COL_W-1:0] inc_col_i,
  input  logic             clr_en_i,
  input  logic [COL_W-1:0] rd_col_i,
  output logic [CNT_W-1:0] rd_cnt_o
);

  logic [CNT_W-1:0] cnt_q [C_COLS];

  for (genvar i = 0; i < C_COLS; i++) begin : g_col
    localparam logic [COL_W-1:0] COL_IDX = COL_W'(i);
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q[i] <= '0;
      end else if (clr_en_i && rd_col_i == COL_IDX) begin
        cnt_q[i] <= '0;
      end else if (inc_en_i && inc_col_i == COL_IDX && cnt_q[i] != CNT_MAX) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_comb begin
    rd_cnt_o = '0;
    for (int k = 0; k < C_COLS; k++) begin
      if (rd_col_i == COL_W'(k)) rd_cnt_o = cnt_q[k];
    end
  end

endmodule

`default_nettype wire

// File: rtl/ball_track_ctrl.sv
//------------------------------------------------------------------------------
// Module   : ball_track_ctrl
// Brief    : Scans a frame, red-filters it and reports the reddest column.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ball_track_ctrl
  import ball_track_ctrl_pkg::*;
#(
  parameter int C_IMG_COLS    = IMG_COLS,
  parameter int C_IMG_ROWS    = IMG_ROWS,
  parameter int C_NB_IMG_PXLS = 13,
  parameter int C_NB_BUF      = 12,
  parameter int C_MIN_PXLS    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_done,
  output logic [C_NB_IMG_PXLS-1:0] orig_addr,
  input  logic [C_NB_BUF-1:0]      orig_pxl,
  output logic                     proc_we,
  output logic [C_NB_IMG_PXLS-1:0] proc_addr,
  output logic [C_NB_BUF-1:0]      proc_pxl,
  output logic                     busy,
  output logic                     result_valid,
  output logic                     ball_found,
  output logic [6:0]               ball_col,
  output logic [7:0]               leds,
  output logic                     frame_ovf
);

  localparam logic [C_NB_IMG_PXLS-1:0] LAST_ADDR = C_NB_IMG_PXLS'(C_IMG_COLS*C_IMG_ROWS-1);
  localparam logic [COL_W-1:0]         LAST_COL  = COL_W'(C_IMG_COLS-1);
  localparam logic [ROW_W-1:0]         LAST_ROW  = ROW_W'(C_IMG_ROWS-1);
  localparam logic [CNT_W-1:0]         MIN_CNT   = CNT_W'(C_MIN_PXLS);

  state_e                     state_q;
  logic                       pending_q, ovf_q;
  logic [C_NB_IMG_PXLS-1:0]   addr_q, proc_addr_q;
  logic [COL_W-1:0]           col_q, pix_col_q, srch_col_q, max_col_q, ball_col_q;
  logic [ROW_W-1:0]           row_q;
  logic                       rd_valid_q;
  logic [CNT_W-1:0]           max_cnt_q;
  logic                       result_valid_q, ball_found_q;
  logic [7:0]                 leds_q;

  logic                       w_red_hit;
  logic [CNT_W-1:0]           w_hist_cnt;

  // Pixel data lags the address by one cycle, so the returned pixel is valid while rd_valid_q.
  assign w_red_hit = rd_valid_q && orig_pxl[RED_BIT];

  col_hist #(.C_COLS(C_IMG_COLS)) u_col_hist (
    .clk       (clk),
    .rst       (rst),
    .inc_en_i  (w_red_hit),
    .inc_col_i (pix_col_q),
    .clr_en_i  (state_q == ST_SEARCH),
    .rd_col_i  (srch_col_q),
    .rd_cnt_o  (w_hist_cnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      pending_q      <= 1'b0;
      ovf_q          <= 1'b0;
      addr_q         <= '0;
      col_q          <= '0;
      row_q          <= '0;
      rd_valid_q     <= 1'b0;
      pix_col_q      <= '0;
      proc_addr_q    <= '0;
      srch_col_q     <= '0;
      max_cnt_q      <= '0;
      max_col_q      <= '0;
      result_valid_q <= 1'b0;
      ball_found_q   <= 1'b0;
      ball_col_q     <= '0;
      leds_q         <= '0;
    end else begin
      result_valid_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      if (frame_done && state_q != ST_IDLE) begin
        if (!pending_q) pending_q <= 1'b1;
        else            ovf_q     <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (frame_done || pending_q) begin
            pending_q <= 1'b0;
            addr_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            state_q   <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          rd_valid_q  <= 1'b1;
          proc_addr_q <= addr_q;
          pix_col_q   <= col_q;
          if (addr_q == LAST_ADDR) begin
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q <= addr_q + 1'b1;
            if (col_q == LAST_COL) begin
              col_q <= '0;
              row_q <= (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          srch_col_q <= '0;
          max_cnt_q  <= '0;
          max_col_q  <= '0;
          state_q    <= ST_SEARCH;
        end
        ST_SEARCH: begin
          // Strict compare keeps the lowest column on ties.
          if (w_hist_cnt > max_cnt_q) begin
            max_cnt_q <= w_hist_cnt;
            max_col_q <= srch_col_q;
          end
          if (srch_col_q == LAST_COL) state_q    <= ST_REPORT;
          else                        srch_col_q <= srch_col_q + 1'b1;
        end
        ST_REPORT: begin
          result_valid_q <= 1'b1;
          ball_col_q     <= max_col_q;
          ball_found_q   <= (max_cnt_q >= MIN_CNT);
          leds_q         <= (max_cnt_q >= MIN_CNT) ? octant_leds(max_col_q) : 8'h00;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign orig_addr    = addr_q;
  assign proc_we      = rd_valid_q;
  assign proc_addr    = proc_addr_q;
  assign proc_pxl     = w_red_hit ? orig_pxl : '0;
  assign busy         = (state_q != ST_IDLE);
  assign result_valid = result_valid_q;
  assign ball_found   = ball_found_q;
  assign ball_col     = ball_col_q;
  assign leds         = leds_q;
  assign frame_ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_ball_track_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_ball_track_ctrl
// Brief    : Directed self-checking bench for ball_track_ctrl.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ball_track_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_done;
  logic [12:0] orig_addr;
  logic [11:0] orig_pxl = '0;
  logic        proc_we;
  logic [12:0] proc_addr;
  logic [11:0] proc_pxl;
  logic        busy, result_valid, ball_found, frame_ovf;
  logic [6:0]  ball_col;
  logic [7:0]  leds;

  logic [11:0] mem [4800];
  logic [11:0] proc_mem [4800];
  int          wr_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  ball_track_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_done   (frame_done),
    .orig_addr    (orig_addr),
    .orig_pxl     (orig_pxl),
    .proc_we      (proc_we),
    .proc_addr    (proc_addr),
    .proc_pxl     (proc_pxl),
    .busy         (busy),
    .result_valid (result_valid),
    .ball_found   (ball_found),
    .ball_col     (ball_col),
    .leds         (leds),
    .frame_ovf    (frame_ovf)
  );

  // Synchronous-read frame buffer and processed-buffer capture.
  always @(posedge clk) begin
    orig_pxl <= mem[orig_addr];
    if (proc_we) begin
      proc_mem[proc_addr] <= proc_pxl;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4800; i++) mem[i] = 12'h000;
  endtask

  task automatic paint(input int col, input int row0, input int nrows, input logic [11:0] val);
    for (int r = row0; r < row0 + nrows; r++) mem[r*80 + col] = val | 12'(r);
  endtask

  // Pulses frame_done and counts cycles until result_valid (bounded).
  task automatic run_frame(output int lat);
    frame_done = 1'b1;
    lat = 0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      frame_done = 1'b0;
      lat++;
      if (result_valid) break;
    end
  endtask

  initial begin
    int lat, lat2, wr0;
    rst = 1'b0;
    frame_done = 1'b0;
    for (int i = 0; i < 4800; i++) proc_mem[i] = 12'hFFF;
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    check("rst_col", 32'(ball_col), 32'd0);
    check("rst_ovf", 32'(frame_ovf), 32'd0);
    check("rst_we", 32'(proc_we), 32'd0);
    check("rst_addr", 32'(orig_addr), 32'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // All-black frame.
    wr0 = wr_cnt;
    run_frame(lat);
    check("black_lat", 32'(lat), 32'd4883);
    check("black_found", 32'(ball_found), 32'd0);
    check("black_leds", 32'(leds), 32'd0);
    check("black_writes", 32'(wr_cnt - wr0), 32'd4800);
    @(posedge clk); #1;
    check("rv_pulse", 32'(result_valid), 32'd0);

    // Column 25 red rows 0..9, plus non-red clutter in column 60.
    paint(25, 0, 10, 12'h800);
    paint(60, 0, 5, 12'h7F0);
    wr0 = wr_cnt;
    run_frame(lat);
    check("c25_lat", 32'(lat), 32'd4883);
    check("c25_col", 32'(ball_col), 32'd25);
    check("c25_found", 32'(ball_found), 32'd1);
    check("c25_leds", 32'(leds), 32'h20);
    check("c25_writes", 32'(wr_cnt - wr0), 32'd4800);
    check("proc_red", 32'(proc_mem[3*80 + 25]), 32'h803);
    check("proc_nonred", 32'(proc_mem[2*80 + 60]), 32'h000);

    // Tie between columns 12 and 70.
    clear_mem();
    paint(12, 20, 10, 12'hF00);
    paint(70, 40, 10, 12'h900);
    run_frame(lat);
    check("tie_col", 32'(ball_col), 32'd12);
    check("tie_found", 32'(ball_found), 32'd1);
    check("tie_leds", 32'(leds), 32'h40);

    // Below threshold in column 40.
    clear_mem();
    paint(40, 7, 3, 12'h800);
    run_frame(lat);
    check("weak_col", 32'(ball_col), 32'd40);
    check("weak_found", 32'(ball_found), 32'd0);
    check("weak_leds", 32'(leds), 32'h00);

    // Two extra frame_done pulses during SCAN.
    clear_mem();
    paint(25, 0, 10, 12'h800);
    frame_done = 1'b1;
    lat = 0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      lat++;
      frame_done = (lat == 100 || lat == 200);
      if (result_valid) break;
    end
    frame_done = 1'b0;
    check("ovf_lat", 32'(lat), 32'd4883);
    check("ovf_col1", 32'(ball_col), 32'd25);
    check("ovf_flag", 32'(frame_ovf), 32'd1);
    clear_mem();
    paint(70, 0, 10, 12'h800);
    lat2 = 0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      lat2++;
      if (result_valid) break;
    end
    check("ovf_lat2", 32'(lat2), 32'd4883);
    check("ovf_col2", 32'(ball_col), 32'd70);
    check("ovf_leds2", 32'(leds), 32'h01);

    // Reset mid-SCAN, then a fresh frame.
    clear_mem();
    paint(25, 0, 10, 12'h800);
    frame_done = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1;
      frame_done = 1'b0;
      if (orig_addr == 13'd2000) break;
    end
    check("mid_addr", 32'(orig_addr), 32'd2000);
    rst = 1'b0;
    #1;
    check("mid_busy", 32'(busy), 32'd0);
    check("mid_ovf", 32'(frame_ovf), 32'd0);
    check("mid_leds", 32'(leds), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (result_valid || busy) lat++;
    end
    check("mid_quiet", 32'(lat), 32'd0);
    clear_mem();
    paint(40, 10, 5, 12'h800);
    run_frame(lat);
    check("new_lat", 32'(lat), 32'd4883);
    check("new_col", 32'(ball_col), 32'd40);
    check("new_found", 32'(ball_found), 32'd1);
    check("new_leds", 32'(leds), 32'h08);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
